input_router_ctrl: RTL and testbench

Sequencer for the bank of ROW_COUNT row routers in the input-router stage. It runs each tile in order: clears router state, loads one address vector per row into the MPP FIFOs, sweeps SRAM reads and forwards the returned address and valid to the address comparators, then pops the MISO FIFOs in lockstep into the PE array. It has one clock domain and holds the tile's pooling mode stable for the whole tile.

---
 rtl/input_router_ctrl_pkg.sv | 23 ++
 rtl/input_router_ctrl_sweeper.sv | 58 +++++
 rtl/input_router_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_input_router_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_router_ctrl_pkg.sv
// Shared types and constants for the input-router stage sequencer.
package input_router_ctrl_pkg;

    // SRAM returns data exactly one cycle after a read is issued.
    localparam int SRAM_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        FETCH = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Debug view of the sequencer: FSM state plus sweeper status.
    typedef struct packed {
        state_e state;
        logic   sweep_wrap;
        logic   sweep_limit;
    } dbg_t;

endpackage

// File: rtl/input_router_ctrl_sweeper.sv
// SRAM window sweeper: walks start..end inclusive, wraps back to start and
// counts completed sweeps so the controller can give up on a stuck tile.
module sram_addr_sweeper
    import input_router_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int MAX_SWEEPS  = 4,
    parameter int SWEEP_CNT_W = $clog2(MAX_SWEEPS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [ADDR_WIDTH-1:0] i_start,
    input  logic [ADDR_WIDTH-1:0] i_end,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_wrap,
    output logic                  o_limit
);

    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [SWEEP_CNT_W-1:0] sweep_q, sweep_d;

    // Wrap is taken on the end address itself, so an end of all-ones never
    // rolls over to zero; it always returns to start.
    assign o_wrap  = (addr_q == i_end);
    assign o_limit = (sweep_q == SWEEP_CNT_W'(MAX_SWEEPS));
    assign o_addr  = addr_q;

    // Next address / sweep count: reload on a new tile, advance per read.
    always_comb begin
        addr_d  = addr_q;
        sweep_d = sweep_q;
        if (i_load) begin
            addr_d  = i_start;
            sweep_d = '0;
        end else if (i_step) begin
            if (o_wrap) begin
                addr_d  = i_start;
                sweep_d = sweep_q + SWEEP_CNT_W'(1);
            end else begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Address and sweep counter registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            addr_q  <= '0;
            sweep_q <= '0;
        end else begin
            addr_q  <= addr_d;
            sweep_q <= sweep_d;
        end
    end

endmodule

// File: rtl/input_router_ctrl.sv
// Tile sequencer for the row-router bank: clear, load one address vector per
// row, sweep SRAM reads into the comparators, then pop MISO columns in
// lockstep into the PE array.
//
// Handshakes: a vector transfers on a cycle where o_ag_ready and i_ag_valid
// are both high; a MISO column transfers on a cycle where o_miso_pop_en is
// high, which already requires i_out_ready and every MISO non-empty.
module input_router_ctrl
    import input_router_ctrl_pkg::*;
#(
    parameter int ROW_COUNT   = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int MAX_SWEEPS  = 4,
    parameter int SWEEP_CNT_W = $clog2(MAX_SWEEPS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_addr_start,
    input  logic [ADDR_WIDTH-1:0] i_addr_end,
    input  logic [1:0]            i_p_mode,
    input  logic                  i_ag_valid,
    output logic                  o_ag_ready,
    output logic [ROW_COUNT-1:0]  o_mpp_write_en,
    output logic                  o_reg_clear,
    output logic                  o_sram_re,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_data_valid,
    output logic [ADDR_WIDTH-1:0] o_data_addr,
    output logic                  o_ac_en,
    input  logic [ROW_COUNT-1:0]  i_mpp_empty,
    input  logic [ROW_COUNT-1:0]  i_miso_empty,
    input  logic                  i_out_ready,
    output logic                  o_miso_pop_en,
    output logic [1:0]            o_p_mode,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic                  o_cfg_err,
    output dbg_t                  o_dbg
);

    localparam int ROW_W = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;

    state_e                state_q, state_d;
    logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0] start_q, end_q;
    logic [1:0]            p_mode_q;
    logic                  cfg_err_q;
    logic                  timed_out_q;
    logic                  data_valid_q;
    logic [ADDR_WIDTH-1:0] data_addr_q;

    logic                  abort_act;
    logic                  start_ok;
    logic                  start_bad;
    logic                  last_row;
    logic                  sweep_load;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  sweep_wrap;
    logic                  sweep_limit;

    logic                  reg_clear;
    logic                  ag_ready;
    logic [ROW_COUNT-1:0]  mpp_we;
    logic                  sram_re;
    logic                  ac_en;
    logic                  pop_en;
    logic                  timeout;
    logic                  done;

    assign abort_act  = i_abort && (state_q != IDLE);
    assign start_bad  = (state_q == IDLE) && i_start && (i_addr_start > i_addr_end);
    assign start_ok   = (state_q == IDLE) && i_start && !(i_addr_start > i_addr_end);
    assign last_row   = (row_cnt_q == ROW_W'(ROW_COUNT - 1));
    // The window registers are stable during CLEAR, so the sweeper loads then.
    assign sweep_load = (state_q == CLEAR);

    sram_addr_sweeper #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MAX_SWEEPS  (MAX_SWEEPS),
        .SWEEP_CNT_W (SWEEP_CNT_W)
    ) u_sweeper (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_load  (sweep_load),
        .i_step  (sram_re),
        .i_start (start_q),
        .i_end   (end_q),
        .o_addr  (sweep_addr),
        .o_wrap  (sweep_wrap),
        .o_limit (sweep_limit)
    );

    // Next-state and per-state outputs; abort overrides everything last.
    always_comb begin
        state_d   = state_q;
        reg_clear = 1'b0;
        ag_ready  = 1'b0;
        mpp_we    = '0;
        sram_re   = 1'b0;
        ac_en     = 1'b0;
        pop_en    = 1'b0;
        timeout   = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = CLEAR;
            end
            CLEAR: begin
                reg_clear = 1'b1;
                state_d   = LOAD;
            end
            LOAD: begin
                ag_ready = 1'b1;
                if (i_ag_valid) begin
                    mpp_we = ROW_COUNT'(1) << row_cnt_q;
                    if (last_row) state_d = FETCH;
                end
            end
            FETCH: begin
                ac_en = 1'b1;
                if (&i_mpp_empty) begin
                    state_d = DRAIN;
                end else if (sweep_limit) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end else begin
                    sram_re = 1'b1;
                end
            end
            DRAIN: begin
                // Comparators stay enabled so the last in-flight read lands.
                ac_en = 1'b1;
                if (&i_miso_empty) state_d = DONE;
            end
            DONE: begin
                // A timed-out tile still passes through DONE but is not "done".
                done    = !timed_out_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Columns only leave when every row has one, keeping them aligned.
        if ((state_q == FETCH || state_q == DRAIN) && !(|i_miso_empty) && i_out_ready)
            pop_en = 1'b1;
        if (abort_act) begin
            state_d   = IDLE;
            reg_clear = 1'b1;
            mpp_we    = '0;
            sram_re   = 1'b0;
            pop_en    = 1'b0;
            timeout   = 1'b0;
            done      = 1'b0;
        end
    end

    // Row counter: advances per accepted vector, restarts for every tile.
    always_comb begin
        row_cnt_d = row_cnt_q;
        if (abort_act || state_q == CLEAR) begin
            row_cnt_d = '0;
        end else if (state_q == LOAD && i_ag_valid) begin
            row_cnt_d = last_row ? '0 : row_cnt_q + ROW_W'(1);
        end
    end

    // FSM state and row counter registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Tile configuration, latched when a well-formed start is accepted.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            start_q  <= '0;
            end_q    <= '0;
            p_mode_q <= '0;
        end else if (start_ok) begin
            start_q  <= i_addr_start;
            end_q    <= i_addr_end;
            p_mode_q <= i_p_mode;
        end
    end

    // Status flags: config-error pulse and timed-out marker for DONE.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            cfg_err_q   <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            cfg_err_q <= start_bad;
            if (start_ok)     timed_out_q <= 1'b0;
            else if (timeout) timed_out_q <= 1'b1;
        end
    end

    // Read-return pipeline matching the one-cycle SRAM latency.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            data_valid_q <= 1'b0;
            data_addr_q  <= '0;
        end else if (abort_act) begin
            data_valid_q <= 1'b0;
            data_addr_q  <= '0;
        end else begin
            data_valid_q <= sram_re;
            data_addr_q  <= o_sram_addr;
        end
    end

    assign o_ag_ready     = ag_ready && !abort_act;
    assign o_mpp_write_en = mpp_we;
    assign o_reg_clear    = reg_clear;
    assign o_sram_re      = sram_re;
    assign o_sram_addr    = (state_q == FETCH) ? sweep_addr : '0;
    assign o_data_valid   = data_valid_q;
    assign o_data_addr    = data_addr_q;
    assign o_ac_en        = ac_en;
    assign o_miso_pop_en  = pop_en;
    assign o_p_mode       = p_mode_q;
    assign o_busy         = (state_q != IDLE);
    assign o_done         = done;
    assign o_timeout      = timeout;
    assign o_cfg_err      = cfg_err_q;
    assign o_dbg          = '{state: state_q, sweep_wrap: sweep_wrap, sweep_limit: sweep_limit};

endmodule

// File: tb/tb_input_router_ctrl.sv
// Directed bench for the input-router tile sequencer.
module tb_input_router_ctrl;
    import input_router_ctrl_pkg::*;

    localparam int RC = 8;
    localparam int AW = 8;

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [AW-1:0] i_addr_start = '0;
    logic [AW-1:0] i_addr_end = '0;
    logic [1:0]    i_p_mode = '0;
    logic          i_ag_valid = 1'b0;
    logic [RC-1:0] i_mpp_empty = '1;
    logic [RC-1:0] i_miso_empty = '1;
    logic          i_out_ready = 1'b1;
    logic          o_ag_ready;
    logic [RC-1:0] o_mpp_write_en;
    logic          o_reg_clear;
    logic          o_sram_re;
    logic [AW-1:0] o_sram_addr;
    logic          o_data_valid;
    logic [AW-1:0] o_data_addr;
    logic          o_ac_en;
    logic          o_miso_pop_en;
    logic [1:0]    o_p_mode;
    logic          o_busy;
    logic          o_done;
    logic          o_timeout;
    logic          o_cfg_err;
    dbg_t          o_dbg;

    int n_checks = 0;
    int n_fail = 0;

    input_router_ctrl #(.ROW_COUNT(RC), .ADDR_WIDTH(AW), .MAX_SWEEPS(4)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_abort(i_abort),
        .i_addr_start(i_addr_start), .i_addr_end(i_addr_end), .i_p_mode(i_p_mode),
        .i_ag_valid(i_ag_valid), .o_ag_ready(o_ag_ready), .o_mpp_write_en(o_mpp_write_en),
        .o_reg_clear(o_reg_clear), .o_sram_re(o_sram_re), .o_sram_addr(o_sram_addr),
        .o_data_valid(o_data_valid), .o_data_addr(o_data_addr), .o_ac_en(o_ac_en),
        .i_mpp_empty(i_mpp_empty), .i_miso_empty(i_miso_empty), .i_out_ready(i_out_ready),
        .o_miso_pop_en(o_miso_pop_en), .o_p_mode(o_p_mode), .o_busy(o_busy),
        .o_done(o_done), .o_timeout(o_timeout), .o_cfg_err(o_cfg_err), .o_dbg(o_dbg)
    );

    // Clock: 10 ns period; inputs change 1 ns after rising edge, checks on falling edge.
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Accept a tile and walk through CLEAR; leaves the DUT in LOAD.
    task automatic start_tile(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic [1:0] pm);
        i_start = 1'b1; i_addr_start = s; i_addr_end = e; i_p_mode = pm;
        @(negedge i_clk);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL start_idle_busy: got %0h exp 0", o_busy); end
        tick();
        i_start = 1'b0;
        @(negedge i_clk);
        n_checks++; if ({o_reg_clear, o_busy, o_ag_ready} !== 3'b110) begin n_fail++; $display("FAIL clear_cycle: got %b exp 110", {o_reg_clear, o_busy, o_ag_ready}); end
        n_checks++; if (o_p_mode !== pm) begin n_fail++; $display("FAIL p_mode_latch: got %0h exp %0h", o_p_mode, pm); end
        tick();
    endtask

    // Feed one vector per row; an optional one-cycle valid gap at gap_at.
    task automatic load_rows(input int gap_at);
        logic [RC-1:0] exp_we;
        for (int r = 0; r < RC; r++) begin
            if (r == gap_at) begin
                i_ag_valid = 1'b0;
                @(negedge i_clk);
                n_checks++; if ({o_ag_ready, o_mpp_write_en} !== {1'b1, {RC{1'b0}}}) begin n_fail++; $display("FAIL load_gap: got %b exp 1_%0b", {o_ag_ready, o_mpp_write_en}, 0); end
                tick();
            end
            i_ag_valid = 1'b1;
            exp_we = RC'(1) << r;
            @(negedge i_clk);
            n_checks++; if ({o_ag_ready, o_mpp_write_en} !== {1'b1, exp_we}) begin n_fail++; $display("FAIL load_we row %0d: got %b exp 1_%b", r, {o_ag_ready, o_mpp_write_en}, exp_we); end
            tick();
        end
        i_ag_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        n_checks++; if ({o_ag_ready, o_mpp_write_en, o_reg_clear, o_sram_re, o_sram_addr, o_data_valid, o_data_addr, o_ac_en, o_miso_pop_en, o_p_mode, o_busy, o_done, o_timeout, o_cfg_err} !== 36'h0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", {o_ag_ready, o_mpp_write_en, o_reg_clear, o_sram_re, o_sram_addr, o_data_valid, o_data_addr, o_ac_en, o_miso_pop_en, o_p_mode, o_busy, o_done, o_timeout, o_cfg_err}); end
        tick();
        i_nrst = 1'b1;
        @(negedge i_clk);
        n_checks++; if (o_dbg.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", o_dbg.state, IDLE); end
        tick();
    endtask

    task automatic test_nominal();
        logic [AW-1:0] exp_addr [6] = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd4, 8'd5};
        start_tile(8'd4, 8'd7, 2'd2);
        load_rows(3);
        i_miso_empty = '0; i_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_mpp_empty = '0;
            @(negedge i_clk);
            n_checks++; if ({o_sram_re, o_ac_en, o_miso_pop_en, o_sram_addr} !== {3'b111, exp_addr[k]}) begin n_fail++; $display("FAIL nom_read %0d: got re/ac/pop=%b addr=%0d exp 111 addr=%0d", k, {o_sram_re, o_ac_en, o_miso_pop_en}, o_sram_addr, exp_addr[k]); end
            if (k > 0) begin
                n_checks++; if ({o_data_valid, o_data_addr} !== {1'b1, exp_addr[k-1]}) begin n_fail++; $display("FAIL nom_data %0d: got v=%b a=%0d exp v=1 a=%0d", k, o_data_valid, o_data_addr, exp_addr[k-1]); end
            end
            tick();
        end
        i_mpp_empty = '1;
        @(negedge i_clk);
        n_checks++; if ({o_sram_re, o_data_valid, o_data_addr} !== {2'b01, 8'd5}) begin n_fail++; $display("FAIL nom_mpp_empty: got re=%b v=%b a=%0d exp re=0 v=1 a=5", o_sram_re, o_data_valid, o_data_addr); end
        tick();
        @(negedge i_clk);
        n_checks++; if ({o_dbg.state, o_ac_en, o_miso_pop_en, o_data_valid} !== {DRAIN, 3'b110}) begin n_fail++; $display("FAIL nom_drain: got %b exp %b", {o_dbg.state, o_ac_en, o_miso_pop_en, o_data_valid}, {DRAIN, 3'b110}); end
        tick();
        i_miso_empty = '1;
        @(negedge i_clk);
        n_checks++; if ({o_miso_pop_en, o_done} !== 2'b00) begin n_fail++; $display("FAIL nom_drain_last: got %b exp 00", {o_miso_pop_en, o_done}); end
        tick();
        @(negedge i_clk);
        n_checks++; if ({o_done, o_busy, o_timeout} !== 3'b110) begin n_fail++; $display("FAIL nom_done: got %b exp 110", {o_done, o_busy, o_timeout}); end
        tick();
        @(negedge i_clk);
        n_checks++; if ({o_done, o_busy, o_p_mode, o_data_valid} !== 5'b00100) begin n_fail++; $display("FAIL nom_idle: got %b exp 00100", {o_done, o_busy, o_p_mode, o_data_valid}); end
        tick();
    endtask

    // Window at the top of the address space, with output backpressure.
    task automatic test_backpressure();
        logic [AW-1:0] s = 8'd254;
        logic [AW-1:0] e = 8'd255;
        logic [AW-1:0] exp_addr;
        logic          exp_pop;
        start_tile(s, e, 2'd1);
        load_rows(99);
        exp_addr = s;
        for (int c = 0; c < 8; c++) begin
            i_mpp_empty = '0;
            i_out_ready = (c >= 1 && c <= 5) ? 1'b0 : 1'b1;
            i_miso_empty = (c == 7) ? 8'h04 : 8'h00;
            exp_pop = (c == 0 || c == 6);
            @(negedge i_clk);
            n_checks++; if ({o_sram_re, o_sram_addr} !== {1'b1, exp_addr}) begin n_fail++; $display("FAIL bp_addr %0d: got re=%b a=%0d exp re=1 a=%0d", c, o_sram_re, o_sram_addr, exp_addr); end
            n_checks++; if (o_miso_pop_en !== exp_pop) begin n_fail++; $display("FAIL bp_pop %0d: got %b exp %b", c, o_miso_pop_en, exp_pop); end
            exp_addr = (exp_addr == e) ? s : exp_addr + 8'd1;
            tick();
        end
        i_out_ready = 1'b1; i_mpp_empty = '1; i_miso_empty = '1;
        @(negedge i_clk);
        n_checks++; if ({o_sram_re, o_timeout} !== 2'b00) begin n_fail++; $display("FAIL bp_last: got %b exp 00", {o_sram_re, o_timeout}); end
        repeat (2) tick();
        @(negedge i_clk);
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b exp 1", o_done); end
        tick();
    endtask

    task automatic test_timeout();
        start_tile(8'd10, 8'd10, 2'd3);
        load_rows(99);
        i_mpp_empty = '0; i_miso_empty = '1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            n_checks++; if ({o_sram_re, o_timeout, o_sram_addr} !== {2'b10, 8'd10}) begin n_fail++; $display("FAIL to_read %0d: got re=%b to=%b a=%0d exp re=1 to=0 a=10", k, o_sram_re, o_timeout, o_sram_addr); end
            tick();
        end
        @(negedge i_clk);
        n_checks++; if ({o_sram_re, o_timeout} !== 2'b01) begin n_fail++; $display("FAIL to_pulse: got %b exp 01", {o_sram_re, o_timeout}); end
        tick();
        @(negedge i_clk);
        n_checks++; if ({o_done, o_timeout, o_busy} !== 3'b001) begin n_fail++; $display("FAIL to_no_done: got %b exp 001", {o_done, o_timeout, o_busy}); end
        tick();
        @(negedge i_clk);
        n_checks++; if ({o_done, o_busy} !== 2'b00) begin n_fail++; $display("FAIL to_idle: got %b exp 00", {o_done, o_busy}); end
        i_mpp_empty = '1;
        tick();
    endtask

    task automatic test_cfg_err();
        i_start = 1'b1; i_addr_start = 8'd9; i_addr_end = 8'd3; i_p_mode = 2'd0;
        @(negedge i_clk);
        n_checks++; if ({o_cfg_err, o_busy, o_reg_clear} !== 3'b000) begin n_fail++; $display("FAIL cfg_req: got %b exp 000", {o_cfg_err, o_busy, o_reg_clear}); end
        tick();
        i_start = 1'b0;
        @(negedge i_clk);
        n_checks++; if ({o_cfg_err, o_busy, o_reg_clear, o_p_mode} !== 5'b10011) begin n_fail++; $display("FAIL cfg_pulse: got %b exp 10011", {o_cfg_err, o_busy, o_reg_clear, o_p_mode}); end
        tick();
        @(negedge i_clk);
        n_checks++; if ({o_cfg_err, o_busy} !== 2'b00) begin n_fail++; $display("FAIL cfg_after: got %b exp 00", {o_cfg_err, o_busy}); end
        tick();
    endtask

    task automatic test_abort();
        logic [AW-1:0] clean_addr [3] = '{8'd1, 8'd2, 8'd1};
        start_tile(8'd20, 8'd30, 2'd1);
        load_rows(99);
        i_mpp_empty = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            n_checks++; if (o_sram_addr !== AW'(20 + k)) begin n_fail++; $display("FAIL ab_addr %0d: got %0d exp %0d", k, o_sram_addr, 20 + k); end
            tick();
        end
        i_abort = 1'b1;
        @(negedge i_clk);
        n_checks++; if ({o_reg_clear, o_sram_re, o_done} !== 3'b100) begin n_fail++; $display("FAIL ab_same_cycle: got %b exp 100", {o_reg_clear, o_sram_re, o_done}); end
        tick();
        i_abort = 1'b0;
        @(negedge i_clk);
        n_checks++; if ({o_busy, o_data_valid, o_reg_clear, o_done} !== 4'b0000) begin n_fail++; $display("FAIL ab_next: got %b exp 0000", {o_busy, o_data_valid, o_reg_clear, o_done}); end
        i_mpp_empty = '1;
        tick();
        start_tile(8'd1, 8'd2, 2'd0);
        load_rows(99);
        for (int k = 0; k < 3; k++) begin
            i_mpp_empty = '0;
            @(negedge i_clk);
            n_checks++; if ({o_sram_re, o_sram_addr} !== {1'b1, clean_addr[k]}) begin n_fail++; $display("FAIL ab_clean %0d: got re=%b a=%0d exp re=1 a=%0d", k, o_sram_re, o_sram_addr, clean_addr[k]); end
            tick();
        end
        i_mpp_empty = '1;
        repeat (2) tick();
        @(negedge i_clk);
        n_checks++; if (o_done !== 1'b1) begin n_fail++; $display("FAIL ab_clean_done: got %b exp 1", o_done); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        start_tile(8'd0, 8'd5, 2'd2);
        for (int r = 0; r < 3; r++) begin
            i_ag_valid = 1'b1;
            tick();
        end
        i_nrst = 1'b0;
        #1;
        n_checks++; if ({o_ag_ready, o_mpp_write_en, o_reg_clear, o_sram_re, o_sram_addr, o_data_valid, o_data_addr, o_ac_en, o_miso_pop_en, o_p_mode, o_busy, o_done, o_timeout, o_cfg_err} !== 36'h0) begin n_fail++; $display("FAIL rst_mid_load: got %h exp 0", {o_ag_ready, o_mpp_write_en, o_reg_clear, o_sram_re, o_sram_addr, o_data_valid, o_data_addr, o_ac_en, o_miso_pop_en, o_p_mode, o_busy, o_done, o_timeout, o_cfg_err}); end
        tick();
        i_ag_valid = 1'b0;
        i_nrst = 1'b1;
        tick();
        start_tile(8'd0, 8'd5, 2'd1);
        i_ag_valid = 1'b1;
        @(negedge i_clk);
        n_checks++; if (o_mpp_write_en !== 8'h01) begin n_fail++; $display("FAIL rst_first_row: got %h exp 01", o_mpp_write_en); end
        tick();
        i_abort = 1'b1;
        @(negedge i_clk);
        n_checks++; if ({o_reg_clear, o_mpp_write_en} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL ab_in_load: got %b exp 1_00000000", {o_reg_clear, o_mpp_write_en}); end
        tick();
        i_abort = 1'b0; i_ag_valid = 1'b0;
        @(negedge i_clk);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ab_load_idle: got %b exp 0", o_busy); end
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_cfg_err();
        test_abort();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
